// File: rtl/led_walk_pkg.sv
// Shared types and step-model helpers for the LED walk decoder.
// The walk is a 16-LED bouncing toggle with HIGH/LOW dwell phases at the ends.
package led_walk_pkg;

  typedef enum logic [1:0] {
    DIR_LOW  = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10,
    DIR_HIGH = 2'b11
  } dir_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_NOTOGGLE = 2'd1;
  localparam logic [1:0] ERR_MULTI    = 2'd2;
  localparam logic [1:0] ERR_POS      = 2'd3;

  typedef struct packed {
    logic [3:0] p;
    dir_t       d;
  } walk_t;

  localparam walk_t WALK_RESET = '{p: 4'd8, d: DIR_UP};

  // Generator step model: where the next toggle lands and the phase after it.
  function automatic walk_t next_step(input logic [3:0] p, input dir_t d);
    walk_t r;
    r = '{p: p, d: d};
    unique case (d)
      DIR_UP: begin
        r.p = p + 4'd1;
        r.d = (p == 4'd14) ? DIR_HIGH : DIR_UP;
      end
      DIR_DOWN: begin
        r.p = p - 4'd1;
        r.d = (p == 4'd1) ? DIR_LOW : DIR_DOWN;
      end
      DIR_HIGH: r.d = DIR_DOWN;
      DIR_LOW:  r.d = DIR_UP;
    endcase
    return r;
  endfunction

  // Best guess of the phase that produced toggle k, given the previous toggle.
  function automatic dir_t resync_guess(input logic [3:0] k, input logic [3:0] last_k);
    dir_t g;
    if (k > last_k)      g = (k == 4'd15) ? DIR_HIGH : DIR_UP;
    else if (k < last_k) g = (k == 4'd0) ? DIR_LOW : DIR_DOWN;
    else                 g = (k >= 4'd8) ? DIR_DOWN : DIR_UP;
    return g;
  endfunction

endpackage

// File: rtl/led_walk_decoder_if.sv
// LED bus and decoded status bundle between a generator-side driver and the decoder.
interface led_walk_decoder_if
  import led_walk_pkg::*;
#(
  parameter int ERR_W = 8
);
  logic             step;
  logic [15:0]      led_in;
  logic [3:0]       pos;
  dir_t             dir;
  logic             valid;
  logic             err;
  logic [1:0]       err_code;
  logic [ERR_W-1:0] err_count;
  logic             locked;

  modport master (
    output step, led_in,
    input  pos, dir, valid, err, err_code, err_count, locked
  );

  modport slave (
    input  step, led_in,
    output pos, dir, valid, err, err_code, err_count, locked
  );
endinterface

// File: rtl/led_onehot_index.sv
// Classifies a 16-bit toggle mask as empty, single-bit or multi-bit and encodes the bit index.
module led_onehot_index (
  input  logic [15:0] diff,
  output logic        is_zero,
  output logic        is_onehot,
  output logic [3:0]  index
);

  assign is_zero   = ~|diff;
  assign is_onehot = ~is_zero & ~|(diff & (diff - 16'd1));

  // OR-encoder: exact when a single bit is set, don't-care otherwise.
  always_comb begin
    index = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (diff[i]) index = index | 4'(i);
    end
  end

endmodule

// File: rtl/led_walk_decoder.sv
// Checks the LED walk bus on each step strobe, tracks position/phase, and reports
// violations with a saturating count and a lock indicator after consecutive clean steps.
module led_walk_decoder
  import led_walk_pkg::*;
#(
  parameter int LOCK_STEPS = 4,
  parameter int ERR_W      = 8
) (
  input  logic                clk,
  input  logic                reset,
  led_walk_decoder_if.slave   bus
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_STEPS);

  logic [15:0]      led_prev_p1, led_prev_nxt;
  walk_t            exp_p1, exp_nxt;
  logic [3:0]       last_k_p1, last_k_nxt;
  logic [3:0]       pos_p1, pos_nxt;
  logic             vld_p1, vld_nxt;
  logic             err_p1, err_nxt;
  logic [1:0]       code_p1, code_nxt;
  logic [ERR_W-1:0] cnt_p1, cnt_nxt;
  logic [3:0]       clean_p1, clean_nxt;
  logic             locked_p1, locked_nxt;

  logic [15:0] diff;
  logic        is_zero, is_onehot;
  logic [3:0]  k;

  assign diff = bus.led_in ^ led_prev_p1;

  led_onehot_index u_onehot (
    .diff      (diff),
    .is_zero   (is_zero),
    .is_onehot (is_onehot),
    .index     (k)
  );

  // Stage p0 -> p1: classify the sampled step and advance the model
  always_comb begin
    led_prev_nxt = led_prev_p1;
    exp_nxt      = exp_p1;
    last_k_nxt   = last_k_p1;
    pos_nxt      = pos_p1;
    vld_nxt      = 1'b0;
    err_nxt      = 1'b0;
    code_nxt     = code_p1;
    cnt_nxt      = cnt_p1;
    clean_nxt    = clean_p1;
    locked_nxt   = locked_p1;

    if (bus.step) begin
      led_prev_nxt = bus.led_in;
      vld_nxt      = 1'b1;
      if (is_zero) begin
        err_nxt  = 1'b1;
        code_nxt = ERR_NOTOGGLE;
      end else if (!is_onehot) begin
        err_nxt  = 1'b1;
        code_nxt = ERR_MULTI;
      end else if (k == exp_p1.p) begin
        exp_nxt    = next_step(exp_p1.p, exp_p1.d);
        pos_nxt    = k;
        last_k_nxt = k;
        code_nxt   = ERR_NONE;
        if (clean_p1 != LOCK_N) clean_nxt = clean_p1 + 4'd1;
      end else begin
        err_nxt    = 1'b1;
        code_nxt   = ERR_POS;
        pos_nxt    = k;
        exp_nxt    = next_step(k, resync_guess(k, last_k_p1));
        last_k_nxt = k;
      end

      if (err_nxt) begin
        clean_nxt = 4'd0;
        if (cnt_p1 != {ERR_W{1'b1}}) cnt_nxt = cnt_p1 + 1'b1;
      end
      locked_nxt = (clean_nxt == LOCK_N);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_prev_p1 <= '0;
      exp_p1      <= WALK_RESET;
      last_k_p1   <= 4'd8;
      pos_p1      <= 4'd0;
      vld_p1      <= 1'b0;
      err_p1      <= 1'b0;
      code_p1     <= ERR_NONE;
      cnt_p1      <= '0;
      clean_p1    <= 4'd0;
      locked_p1   <= 1'b0;
    end else begin
      led_prev_p1 <= led_prev_nxt;
      exp_p1      <= exp_nxt;
      last_k_p1   <= last_k_nxt;
      pos_p1      <= pos_nxt;
      vld_p1      <= vld_nxt;
      err_p1      <= err_nxt;
      code_p1     <= code_nxt;
      cnt_p1      <= cnt_nxt;
      clean_p1    <= clean_nxt;
      locked_p1   <= locked_nxt;
    end
  end

  assign bus.pos       = pos_p1;
  assign bus.dir       = exp_p1.d;
  assign bus.valid     = vld_p1;
  assign bus.err       = err_p1;
  assign bus.err_code  = code_p1;
  assign bus.err_count = cnt_p1;
  assign bus.locked    = locked_p1;

endmodule

// File: tb/tb_led_walk_decoder.sv
// Directed bench for led_walk_decoder: vector table plus walk, saturation and reset sequences.
module tb_led_walk_decoder;
  import led_walk_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  led_walk_decoder_if #(.ERR_W(8)) bus ();

  led_walk_decoder #(.LOCK_STEPS(4), .ERR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [15:0] led_sh;

  typedef struct {
    logic        rst;
    logic [15:0] mask;
    logic        err;
    logic [1:0]  code;
    logic [3:0]  pos;
    logic [1:0]  dir;
    int          cnt;
    logic        locked;
  } vec_t;

  vec_t tbl[24];
  int   seq[40];

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " pos"}, int'(bus.pos), 0);
    chk({tag, " dir"}, int'(bus.dir), 1);
    chk({tag, " valid"}, int'(bus.valid), 0);
    chk({tag, " err"}, int'(bus.err), 0);
    chk({tag, " err_code"}, int'(bus.err_code), 0);
    chk({tag, " err_count"}, int'(bus.err_count), 0);
    chk({tag, " locked"}, int'(bus.locked), 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    bus.step = 1'b0;
    led_sh = 16'h0000;
    bus.led_in = led_sh;
    #1;
    chk_reset_outputs(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Drives one step strobe; returns at the negedge after the processing edge.
  task automatic do_step(input logic [15:0] mask);
    @(negedge clk);
    led_sh = led_sh ^ mask;
    bus.led_in = led_sh;
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
  endtask

  initial begin
    bus.step = 1'b0;
    bus.led_in = 16'h0000;
    led_sh = 16'h0000;

    tbl[0]  = '{1'b1, 16'h0000, 1'b0, 2'd0, 4'd0,  2'd1, 0, 1'b0};
    tbl[1]  = '{1'b0, 16'h0100, 1'b0, 2'd0, 4'd8,  2'd1, 0, 1'b0};
    tbl[2]  = '{1'b0, 16'h0200, 1'b0, 2'd0, 4'd9,  2'd1, 0, 1'b0};
    tbl[3]  = '{1'b0, 16'h0400, 1'b0, 2'd0, 4'd10, 2'd1, 0, 1'b0};
    tbl[4]  = '{1'b0, 16'h0800, 1'b0, 2'd0, 4'd11, 2'd1, 0, 1'b1};
    tbl[5]  = '{1'b0, 16'h1000, 1'b0, 2'd0, 4'd12, 2'd1, 0, 1'b1};
    tbl[6]  = '{1'b0, 16'h0000, 1'b1, 2'd1, 4'd12, 2'd1, 1, 1'b0};
    tbl[7]  = '{1'b0, 16'h2000, 1'b0, 2'd0, 4'd13, 2'd1, 1, 1'b0};
    tbl[8]  = '{1'b0, 16'h0018, 1'b1, 2'd2, 4'd13, 2'd1, 2, 1'b0};
    tbl[9]  = '{1'b0, 16'h4000, 1'b0, 2'd0, 4'd14, 2'd3, 2, 1'b0};
    tbl[10] = '{1'b1, 16'h0000, 1'b0, 2'd0, 4'd0,  2'd1, 0, 1'b0};
    tbl[11] = '{1'b0, 16'h0100, 1'b0, 2'd0, 4'd8,  2'd1, 0, 1'b0};
    tbl[12] = '{1'b0, 16'h0200, 1'b0, 2'd0, 4'd9,  2'd1, 0, 1'b0};
    tbl[13] = '{1'b0, 16'h0008, 1'b1, 2'd3, 4'd3,  2'd2, 1, 1'b0};
    tbl[14] = '{1'b0, 16'h0004, 1'b0, 2'd0, 4'd2,  2'd2, 1, 1'b0};
    tbl[15] = '{1'b0, 16'h0002, 1'b0, 2'd0, 4'd1,  2'd0, 1, 1'b0};
    tbl[16] = '{1'b0, 16'h0001, 1'b0, 2'd0, 4'd0,  2'd1, 1, 1'b0};
    tbl[17] = '{1'b0, 16'h0001, 1'b0, 2'd0, 4'd0,  2'd1, 1, 1'b1};
    tbl[18] = '{1'b0, 16'h8000, 1'b1, 2'd3, 4'd15, 2'd2, 2, 1'b0};
    tbl[19] = '{1'b0, 16'h0020, 1'b1, 2'd3, 4'd5,  2'd2, 3, 1'b0};
    tbl[20] = '{1'b0, 16'h0020, 1'b1, 2'd3, 4'd5,  2'd1, 4, 1'b0};
    tbl[21] = '{1'b0, 16'h0001, 1'b1, 2'd3, 4'd0,  2'd1, 5, 1'b0};
    tbl[22] = '{1'b0, 16'h0200, 1'b1, 2'd3, 4'd9,  2'd1, 6, 1'b0};
    tbl[23] = '{1'b0, 16'h0200, 1'b1, 2'd3, 4'd9,  2'd2, 7, 1'b0};

    begin
      int n;
      n = 0;
      for (int p = 8; p <= 15; p++) begin seq[n] = p; n++; end
      for (int p = 15; p >= 0; p--) begin seq[n] = p; n++; end
      for (int p = 0; n < 40; p++) begin seq[n] = p; n++; end
    end

    // Power-on reset held, then released with no step
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("por");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("idle_after_reset");

    for (int i = 0; i < 24; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      if (tbl[i].rst) begin
        do_reset(tag);
      end else begin
        do_step(tbl[i].mask);
        chk({tag, " valid"}, int'(bus.valid), 1);
        chk({tag, " err"}, int'(bus.err), int'(tbl[i].err));
        chk({tag, " err_code"}, int'(bus.err_code), int'(tbl[i].code));
        chk({tag, " pos"}, int'(bus.pos), int'(tbl[i].pos));
        chk({tag, " dir"}, int'(bus.dir), int'(tbl[i].dir));
        chk({tag, " err_count"}, int'(bus.err_count), tbl[i].cnt);
        chk({tag, " locked"}, int'(bus.locked), int'(tbl[i].locked));
        @(negedge clk);
        chk({tag, " idle valid"}, int'(bus.valid), 0);
        chk({tag, " idle err"}, int'(bus.err), 0);
        chk({tag, " idle err_code"}, int'(bus.err_code), int'(tbl[i].code));
        chk({tag, " idle pos"}, int'(bus.pos), int'(tbl[i].pos));
      end
    end

    // Clean 40-step walk from reset
    do_reset("walk_reset");
    for (int i = 0; i < 40; i++) begin
      string tag;
      tag = $sformatf("walk%0d", i + 1);
      do_step(16'h0001 << seq[i]);
      chk({tag, " err"}, int'(bus.err), 0);
      chk({tag, " valid"}, int'(bus.valid), 1);
      chk({tag, " pos"}, int'(bus.pos), seq[i]);
      chk({tag, " locked"}, int'(bus.locked), (i >= 3) ? 1 : 0);
      if (i == 6)  chk({tag, " dir"}, int'(bus.dir), int'(DIR_HIGH));
      if (i == 7)  chk({tag, " dir"}, int'(bus.dir), int'(DIR_DOWN));
      if (i == 22) chk({tag, " dir"}, int'(bus.dir), int'(DIR_LOW));
      if (i == 23) chk({tag, " dir"}, int'(bus.dir), int'(DIR_UP));
    end
    chk("walk err_count", int'(bus.err_count), 0);

    // Saturation of the error counter under repeated stalls
    do_reset("sat_reset");
    for (int i = 0; i < 300; i++) begin
      do_step(16'h0000);
      if (i == 254) chk("sat count at 255", int'(bus.err_count), 255);
      if (i == 255) chk("sat count no wrap", int'(bus.err_count), 255);
    end
    chk("sat err_count", int'(bus.err_count), 255);
    chk("sat err", int'(bus.err), 1);
    chk("sat err_code", int'(bus.err_code), 1);
    chk("sat locked", int'(bus.locked), 0);

    // Mid-stream reset with step high, then a step on the release cycle
    @(negedge clk);
    bus.step = 1'b1;
    reset = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    @(negedge clk);
    led_sh = 16'h0100;
    bus.led_in = led_sh;
    bus.step = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    chk("release step valid", int'(bus.valid), 1);
    chk("release step err", int'(bus.err), 0);
    chk("release step pos", int'(bus.pos), 8);
    chk("release step dir", int'(bus.dir), int'(DIR_UP));
    chk("release step err_count", int'(bus.err_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
